// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and constants for the two-source AXI3 write arbiter.
// FSM encoding, source IDs, AXI burst/size codes, AW payload bundle.
package axi_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic SRC_WBUF = 1'b0;
  localparam logic SRC_UNC  = 1'b1;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } aw_pay_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_pay_t;

  // Round-robin pick between two eligible sources.
  function automatic logic rr_pick(
    input logic e0,
    input logic e1,
    input logic last
  );
    if (e0 && e1) begin
      return ~last;
    end
    return e1;
  endfunction

endpackage

// File: rtl/axi_wr_outstanding_cnt.sv
// Per-source count of AW-accepted writes whose B has not returned.
// Same-cycle inc and dec cancel; saturates at 0 and at all-ones.
module axi_wr_outstanding_cnt
  import axi_wr_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count from AW (inc) and B (dec) handshakes.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      2'b01: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o  = cnt_q;
  assign at_max_o = (cnt_q >= CNT_W'(MAX));
  assign zero_o   = (cnt_q == '0);

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-source AXI3 write arbiter: write buffer (ID 0) and uncached (ID 1).
// Optional AXI_WR_ARB_ORDER_EN: no source switch while the other has B pending.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s0_awaddr,
  input  logic [3:0]  s0_awlen,
  input  logic [2:0]  s0_awsize,
  input  logic [1:0]  s0_awburst,
  input  logic [1:0]  s0_awlock,
  input  logic [3:0]  s0_awcache,
  input  logic [2:0]  s0_awprot,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_wlast,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  output logic [1:0]  s0_bresp,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  input  logic [31:0] s1_awaddr,
  input  logic [3:0]  s1_awlen,
  input  logic [2:0]  s1_awsize,
  input  logic [1:0]  s1_awburst,
  input  logic [1:0]  s1_awlock,
  input  logic [3:0]  s1_awcache,
  input  logic [2:0]  s1_awprot,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wlast,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic [CNT_W-1:0] cnt0, cnt1;
  logic at_max0, at_max1;
  logic zero0, zero1;
  logic elig0, elig1;

  logic in_addr, in_data;
  logic aw_hs, w_end, b_hs;
  logic bsel;
  logic unused_bid;

  aw_pay_t aw0, aw1, aw_sel;
  w_pay_t  w0, w1, w_sel;

  assign in_addr = (state_q == ARB_ADDR);
  assign in_data = (state_q == ARB_DATA);

  assign bsel       = bid[0];
  assign unused_bid = ^bid[3:1];

  // Source eligibility for a new grant.
  always_comb begin
    elig0 = s0_awvalid & ~at_max0;
    elig1 = s1_awvalid & ~at_max1;
`ifdef AXI_WR_ARB_ORDER_EN
    elig0 = elig0 & (zero1 | (last_grant_q == SRC_WBUF));
    elig1 = elig1 & (zero0 | (last_grant_q == SRC_UNC));
`endif
  end

  // Arbitration FSM next state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (elig0 || elig1) begin
          grant_d      = rr_pick(elig0, elig1, last_grant_q);
          last_grant_d = grant_d;
          state_d      = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (aw_hs) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (w_end) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= SRC_WBUF;
      last_grant_q <= SRC_UNC;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign aw0 = '{s0_awaddr, s0_awlen, s0_awsize, s0_awburst,
                 s0_awlock, s0_awcache, s0_awprot};
  assign aw1 = '{s1_awaddr, s1_awlen, s1_awsize, s1_awburst,
                 s1_awlock, s1_awcache, s1_awprot};
  assign w0  = '{s0_wdata, s0_wstrb, s0_wlast};
  assign w1  = '{s1_wdata, s1_wstrb, s1_wlast};

  // AW channel mux from the granted source.
  always_comb begin
    aw_sel     = grant_q ? aw1 : aw0;
    awaddr     = aw_sel.addr;
    awlen      = aw_sel.len;
    awsize     = aw_sel.size;
    awburst    = aw_sel.burst;
    awlock     = aw_sel.lock;
    awcache    = aw_sel.cache;
    awprot     = aw_sel.prot;
    awid       = {3'b000, grant_q};
    awvalid    = in_addr & (grant_q ? s1_awvalid : s0_awvalid);
    s0_awready = in_addr & (grant_q == SRC_WBUF) & awready;
    s1_awready = in_addr & (grant_q == SRC_UNC) & awready;
    aw_hs      = awvalid & awready;
  end

  // W channel mux from the granted source.
  always_comb begin
    w_sel     = grant_q ? w1 : w0;
    wdata     = w_sel.data;
    wstrb     = w_sel.strb;
    wlast     = w_sel.last;
    wid       = {3'b000, grant_q};
    wvalid    = in_data & (grant_q ? s1_wvalid : s0_wvalid);
    s0_wready = in_data & (grant_q == SRC_WBUF) & wready;
    s1_wready = in_data & (grant_q == SRC_UNC) & wready;
    w_end     = wvalid & wready & wlast;
  end

  // B routing by ID bit 0, independent of the FSM.
  always_comb begin
    s0_bresp  = bresp;
    s1_bresp  = bresp;
    s0_bvalid = bvalid & ~bsel;
    s1_bvalid = bvalid & bsel;
    bready    = bsel ? s1_bready : s0_bready;
    b_hs      = bvalid & bready;
  end

  axi_wr_outstanding_cnt #(
    .MAX(MAX_OUTSTANDING)
  ) u_cnt0 (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (aw_hs & (grant_q == SRC_WBUF)),
    .dec_i   (b_hs & ~bsel),
    .count_o (cnt0),
    .at_max_o(at_max0),
    .zero_o  (zero0)
  );

  axi_wr_outstanding_cnt #(
    .MAX(MAX_OUTSTANDING)
  ) u_cnt1 (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (aw_hs & (grant_q == SRC_UNC)),
    .dec_i   (b_hs & bsel),
    .count_o (cnt1),
    .at_max_o(at_max1),
    .zero_o  (zero1)
  );

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-source AXI3 write-channel arbiter between the write buffer (8-beat line bursts) and the dcache uncached path (single-beat writes) on one side, and the shared AXI write port on the other. It serializes AW+W per transaction, tags each transaction with a source ID, counts outstanding writes per source, and routes B responses back by ID. It replaces the direct dcache-to-AXI uncached pass-through and frees the write buffer from owning the AXI port.

## Interface
- MAX_OUTSTANDING, 8: per-source limit of AW-accepted, B-not-yet-returned writes (1..15)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- s0_awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  32/4/3/2/2/4/3  write-buffer AW payload
- s0_awvalid  in  1;  s0_awready  out  1
- s0_wdata/wstrb/wlast  in  32/4/1;  s0_wvalid  in  1;  s0_wready  out  1
- s0_bresp  out  2;  s0_bvalid  out  1;  s0_bready  in  1
- s1_*  same set as s0_*, uncached dcache source
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  4/32/4/3/2/2/4/3  AXI AW
- awvalid  out  1;  awready  in  1
- wid/wdata/wstrb/wlast  out  4/32/4/1;  wvalid  out  1;  wready  in  1
- bid  in  4;  bresp  in  2;  bvalid  in  1;  bready  out  1

## Operation
- States: IDLE, ADDR, DATA; reset → IDLE, grant=0, last_grant=1, out0=out1=0.
- IDLE: source k eligible if sk_awvalid and outk < MAX_OUTSTANDING. One eligible → grant it. Both → grant the one ≠ last_grant (round-robin). Register grant, last_grant ← grant, go ADDR.
- ADDR: AW payload/awvalid muxed from granted source; sk_awready = awready for granted source, 0 otherwise. awid = {3'b000, grant}. On awvalid&awready: outgrant += 1, go DATA.
- DATA: W muxed from granted source; wid = {3'b000, grant}; sk_wready = wready for granted only. On wvalid&wready&wlast → IDLE. Beat count not checked; wlast ends the burst.
- B path independent of FSM: route by bid[0] (bid[3:1] ignored). s{bid[0]}_bvalid = bvalid, other source's bvalid = 0, bready = s{bid[0]}_bready. bresp forwarded unchanged.
- Counters 4-bit: +1 on AW handshake, −1 on B handshake of that source; same-cycle inc and dec → unchanged. Decrement at 0 does not occur on legal traffic; saturate at 0.
- Non-granted source always sees awready=0, wready=0.

## Timing
- sk_awvalid high in IDLE → awvalid high next cycle (1-cycle grant latency); AW/W/B muxing is combinational, no added latency in ADDR/DATA.
- Back-to-back: after wlast handshake, 1 IDLE cycle before next AW (min 10 cycles per 8-beat line with zero-wait slave).
- Reset outputs: awvalid, wvalid, s0/s1_awready, s0/s1_wready, s0/s1_bvalid = 0; bready = s0_bready passthrough (bid X-safe: treat as 0); awid/wid = 0.
- Source deasserting awvalid in ADDR is illegal (AXI stability); no recovery required.
- Reset mid-burst: immediate return to IDLE, counters cleared; in-flight transactions abandoned, slave is reset together.

## Configuration
- AXI_WR_ARB_ORDER_EN defined: in IDLE, a source is eligible only if the other source's counter is 0 or it was last_grant (no switch until all B responses of the previous source return) — enforces uncached/cached write ordering.
- Not defined: sources interleave freely, limited only by MAX_OUTSTANDING.

## Structure
- Shared package: FSM state encoding (ARB_IDLE, ARB_ADDR, ARB_DATA), source IDs (SRC_WBUF=0, SRC_UNC=1), AXI burst/size constants.
- Sub-module: axi_wr_outstanding_cnt (one per source: inc, dec, count, at_max, zero).

## Test plan
- s1 single write 0x1FC0_0004 data 0xDEADBEEF, wstrb 4'b0011 → awid=1, awlen=0, one W beat wid=1, s1_bvalid on bid=1, out1 back to 0.
- s0 and s1 request same cycle from reset → s0 granted first (8 beats, wid=0), s1 next, 1 IDLE cycle between.
- s0 issues 8 bursts, slave withholds B with MAX_OUTSTANDING=8 → 9th s0 AW blocked, s1 still granted; one bid=0 response → s0 granted next IDLE.
- B for s0 and AW handshake for s0 in same cycle with out0=3 → out0 stays 3.
- With AXI_WR_ARB_ORDER_EN: s0 burst outstanding, s1 requests → no s1 grant until bid=0 returns; without macro → s1 granted immediately after s0 wlast.
- Assert rst during beat 4 of s0 burst → awvalid/wvalid 0 asynchronously, state IDLE, counters 0; next request proceeds normally.
